// File: rtl/euler_pkg.sv
// Shared definitions for the factorisation controller and its iterative divider.
package euler_pkg;

   // Default operand / factor / result width.
   localparam int unsigned WIDTH_DEF = 64;

   // Controller states.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CHECK    = 3'd1,
      DIV_WAIT = 3'd2,
      EMIT     = 3'd3,
      FINAL    = 3'd4,
      DONE     = 3'd5
   } state_t;

endpackage : euler_pkg

// File: rtl/factor_sched_div.sv
// Restoring shift-subtract divider: one quotient bit per enabled cycle.
// done is a one-cycle pulse exactly WIDTH enabled cycles after start;
// quot/rem are valid while done is high.
module div_iter
   import euler_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_div;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;

   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_sub;
   logic             w_ge;

   // Partial remainder shifted left with the next dividend bit, and the trial subtraction.
   always_comb begin
      w_shift = {r_rem, r_quot[WIDTH-1]};
      w_sub   = w_shift - {1'b0, r_div};
      w_ge    = (w_shift >= {1'b0, r_div});
   end

   // Load on start, then one restoring step per enabled cycle until the count expires.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_quot <= {WIDTH{1'b0}};
         r_rem  <= {WIDTH{1'b0}};
         r_div  <= {WIDTH{1'b0}};
         r_cnt  <= {CNT_W{1'b0}};
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else if (enable) begin
         if (start) begin
            r_quot <= dividend;
            r_rem  <= {WIDTH{1'b0}};
            r_div  <= divisor;
            r_cnt  <= CNT_W'(WIDTH);
            r_busy <= 1'b1;
            r_done <= 1'b0;
         end else if (r_busy) begin
            r_quot <= {r_quot[WIDTH-2:0], w_ge};
            r_rem  <= w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_cnt  <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end else begin
               r_done <= 1'b0;
            end
         end else begin
            r_done <= 1'b0;
         end
      end else begin
         r_done <= r_done;
      end
   end

   assign done = r_done;
   assign quot = r_quot;
   assign rem  = r_rem;

endmodule : div_iter

// File: rtl/factor_sched.sv
// Trial-division prime factorisation controller. Streams prime factors in
// non-decreasing order over valid/ready, then presents the largest one.
module factor_sched
   import euler_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             start,
   input  logic [WIDTH-1:0] n_in,
   output logic             busy,
   output logic             factor_valid,
   input  logic             factor_ready,
   output logic [WIDTH-1:0] factor,
   output logic             results_valid,
   output logic [WIDTH-1:0] results
);

   state_t             r_state;
   logic [WIDTH-1:0]   r_y;
   logic [WIDTH-1:0]   r_x;
   logic [WIDTH-1:0]   r_last;
   logic               r_busy;
   logic               r_factor_valid;
   logic [WIDTH-1:0]   r_factor;
   logic               r_results_valid;
   logic [WIDTH-1:0]   r_results;
   logic               r_div_start;

   logic [2*WIDTH-1:0] w_sq;
   logic [2*WIDTH-1:0] w_y_ext;
   logic [WIDTH-1:0]   w_next_x;
   logic               w_div_done;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;

   // Square of the trial divisor at double width, and the next odd candidate.
   always_comb begin
      w_sq     = {{WIDTH{1'b0}}, r_x} * {{WIDTH{1'b0}}, r_x};
      w_y_ext  = {{WIDTH{1'b0}}, r_y};
      if (r_x == WIDTH'(2)) begin
         w_next_x = WIDTH'(3);
      end else begin
         w_next_x = r_x + WIDTH'(2);
      end
   end

   div_iter #(.WIDTH(WIDTH)) u_div (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .start    (r_div_start),
      .dividend (r_y),
      .divisor  (r_x),
      .done     (w_div_done),
      .quot     (w_quot),
      .rem      (w_rem)
   );

   // Controller FSM with registered outputs; everything freezes while enable is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= IDLE;
         r_y             <= {WIDTH{1'b0}};
         r_x             <= {WIDTH{1'b0}};
         r_last          <= {WIDTH{1'b0}};
         r_busy          <= 1'b0;
         r_factor_valid  <= 1'b0;
         r_factor        <= {WIDTH{1'b0}};
         r_results_valid <= 1'b0;
         r_results       <= {WIDTH{1'b0}};
         r_div_start     <= 1'b0;
      end else if (enable) begin
         r_div_start <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_y             <= n_in;
                  r_x             <= WIDTH'(2);
                  r_last          <= {WIDTH{1'b0}};
                  r_busy          <= 1'b1;
                  r_results_valid <= 1'b0;
                  r_state         <= CHECK;
               end else begin
                  r_state <= r_state;
               end
            end
            CHECK: begin
               if (r_y < WIDTH'(2)) begin
                  r_busy          <= 1'b0;
                  r_results_valid <= 1'b1;
                  r_results       <= r_last;
                  r_state         <= DONE;
               end else if (w_sq > w_y_ext) begin
                  r_factor       <= r_y;
                  r_factor_valid <= 1'b1;
                  r_state        <= FINAL;
               end else begin
                  r_div_start <= 1'b1;
                  r_state     <= DIV_WAIT;
               end
            end
            DIV_WAIT: begin
               // done is a single pulse, so it cannot be stale from the previous divide.
               if (w_div_done) begin
                  if (w_rem == {WIDTH{1'b0}}) begin
                     r_y            <= w_quot;
                     r_factor       <= r_x;
                     r_factor_valid <= 1'b1;
                     r_state        <= EMIT;
                  end else begin
                     r_x     <= w_next_x;
                     r_state <= CHECK;
                  end
               end else begin
                  r_state <= DIV_WAIT;
               end
            end
            EMIT: begin
               if (factor_ready) begin
                  r_factor_valid <= 1'b0;
                  r_last         <= r_x;
                  r_state        <= CHECK;
               end else begin
                  r_state <= EMIT;
               end
            end
            FINAL: begin
               if (factor_ready) begin
                  r_factor_valid  <= 1'b0;
                  r_last          <= r_y;
                  r_busy          <= 1'b0;
                  r_results_valid <= 1'b1;
                  r_results       <= r_y;
                  r_state         <= DONE;
               end else begin
                  r_state <= FINAL;
               end
            end
            default: begin
               r_factor_valid  <= 1'b0;
               r_busy          <= 1'b0;
               r_results_valid <= 1'b0;
               r_state         <= IDLE;
            end
         endcase
      end else begin
         r_state <= r_state;
      end
   end

   assign busy          = r_busy;
   assign factor_valid  = r_factor_valid;
   assign factor        = r_factor;
   assign results_valid = r_results_valid;
   assign results       = r_results;

endmodule : factor_sched

// File: doc/factor_sched.md
Name: factor_sched

Overview:
- Trial-division prime-factorisation controller.
- Replaces single-cycle `%` and `/` with a shared iterative shift-subtract divider, which it sequences.
- Accepts a WIDTH-bit operand on `start`, streams every prime factor in non-decreasing order over a valid/ready port, then presents the largest prime factor.
- Sits in the euler problem top level, next to the other result-producing blocks, and uses the same `enable`/`results_valid`/`results` contract.

Parameters:
- WIDTH, 64, operand, factor and result width.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is high.
- enable  in  1  high = advance; low = freeze all state (divider included); outputs hold.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- n_in  in  WIDTH  number to factor, captured when start is accepted.
- busy  out  1  high from start accept until DONE is entered.
- factor_valid  out  1  a prime factor is presented.
- factor_ready  in  1  consumer accepts factor when factor_valid && factor_ready.
- factor  out  WIDTH  current prime factor.
- results_valid  out  1  factorisation complete; held high in DONE.
- results  out  WIDTH  largest prime factor emitted; 0 if none.

Behaviour:
- Reset values: busy=0, factor_valid=0, factor=0, results_valid=0, results=0; state=IDLE; divider idle.
- Internal registers: y (remaining cofactor), x (trial divisor), last (last emitted factor).
- States:
  - IDLE: on start, y<=n_in, x<=2, last<=0, busy<=1 -> CHECK.
  - CHECK (1 cycle), evaluated in this order:
    - if y<2 -> DONE;
    - else if x*x > y (2*WIDTH-bit product, no overflow) -> FINAL;
    - else pulse divider start with (y, x) -> DIV_WAIT.
  - DIV_WAIT: wait for divider done.
    - rem==0: y<=quot, factor<=x, factor_valid<=1 -> EMIT.
    - rem!=0: x<=(x==2) ? 3 : x+2 -> CHECK.
  - EMIT: hold factor/factor_valid stable until handshake. On handshake: factor_valid<=0, last<=x -> CHECK (x unchanged, so repeated factors are found).
  - FINAL: y is prime; factor<=y, factor_valid<=1. On handshake: last<=y -> DONE.
  - DONE: busy=0, results_valid=1, results=last. start is accepted here: results_valid<=0, re-init as in IDLE.
- start while busy: ignored, no effect.
- n_in=0 or 1: CHECK goes straight to DONE; no factor emitted; results=0.
- Divider latency: done asserts exactly WIDTH enabled cycles after its start pulse; quot/rem are valid while done is high.
- enable=0: no state, counter or output changes in any state, including mid-divide and mid-EMIT; factor_ready is ignored while enable=0.
- reset mid-operation: returns to IDLE with reset values on the next edge; any pending factor is dropped.
- Handshake: factor_valid never drops without a transfer; factor stays stable while valid && !ready.
- Arithmetic: all unsigned. x never exceeds 2^(WIDTH/2)+1 before the FINAL exit.

Decomposition:
- Package euler_pkg holds the state enum typedef (IDLE, CHECK, DIV_WAIT, EMIT, FINAL, DONE) and the WIDTH default constant.
- One sub-module, div_iter:
  - restoring shift-subtract divider;
  - ports clk, reset, enable, start, dividend, divisor, done, quot, rem;
  - WIDTH-cycle latency;
  - divisor is never 0 (guaranteed by the controller).

Test Plan:
- n_in=13195, factor_ready tied 1 -> factors 5, 7, 13, 29 in order; results=29; results_valid=1; busy=0.
- n_in=600851475143 -> factors 71, 839, 1471, 6857; results=6857 (0x1AC9).
- n_in=12 -> factors 2, 2, 3; results=3. n_in=97 -> single factor 97 via FINAL; results=97.
- n_in=1 and n_in=0 -> DONE within 3 cycles of start; no factor_valid; results=0.
- Backpressure: n_in=13195, factor_ready low for 10 cycles at first factor -> factor=5 and factor_valid held stable for all 10 cycles, no factor lost; enable low for 20 cycles mid-DIV_WAIT -> total latency grows by exactly 20 cycles, same results.
- Reset mid-DIV_WAIT (n_in=600851475143) -> next cycle: all outputs at reset values; a fresh start with n_in=13195 then completes correctly.
